max_seek_ctrl: RTL
==================

# max_seek_ctrl

Streaming maximum-finder controller: accepts a frame of unsigned words over a valid/ready input and keeps a running maximum with a single shared magnitude comparator. On the frame's last beat it presents the maximum value, its beat index and the beat count on a valid/ready output. It is the sequential wrapper that schedules the greater-than datapath: one comparison per accepted beat, with no duplicated comparators.

## Interface
- WIDTH, 4: data word width in bits, unsigned, ≥ 2 and even.
- IDX_W, 4: width of the beat index and count; frames up to 2**IDX_W beats are exact.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. Deassertion is synchronised externally.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  unsigned input word.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- out_max  out  WIDTH  largest word in the frame.
- out_idx  out  IDX_W  zero-based index of the first occurrence of out_max.
- out_count  out  IDX_W  number of beats in the frame, minus 1.
- out_ovf  out  1  frame exceeded 2**IDX_W beats.

## Operation
- Beat accepted when in_valid & in_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. An accepted beat loads max←in_data, idx←0, cnt←0 and ovf←0.
    - If in_last is also set, go to HOLD.
    - Otherwise go to ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On each accepted beat:
    - cnt increments.
    - If in_data is strictly greater than max (comparator output), set max←in_data and idx←cnt+1.
    - If in_last is set, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, outputs stable. When out_ready=1, go to IDLE.
- Ties keep the earlier index; only "strictly greater" replaces the stored maximum.
- Count saturation:
  - When cnt = 2**IDX_W−1 and another beat arrives, cnt holds and ovf←1. ovf is sticky until the next frame.
  - Beats after saturation are still compared. A replacement then records idx = 2**IDX_W−1.
- out_max, out_idx, out_count and out_ovf are driven directly from the state registers. They hold their last value outside HOLD but are only meaningful while out_valid=1.
- in_valid=0 in ACCUM is a legal stall; state is unchanged.
- in_data and in_last are ignored when no beat is accepted.

## Timing
- Reset values: state=IDLE; in_ready=1, out_valid=0, out_max=0, out_idx=0, out_count=0, out_ovf=0.
- Reset asserted mid-frame or in HOLD aborts immediately. The partial result is discarded and never presented.
- Latency: the result for a last beat accepted at edge N is valid (out_valid=1) in the cycle after edge N. The last beat itself is included in the result.
- Throughput: one beat per cycle inside a frame. There is at least one idle cycle of in_ready=0 between frames (HOLD), and more while out_ready is held low.
- Producer rules: must hold in_valid and in_data stable until accepted. in_ready depends only on state, with no combinational path from in_valid.
- Output rules: out_valid, once high, stays high with stable data until out_ready is seen. out_ready has no combinational path to in_ready.
- Single-beat frame (first beat has in_last): IDLE→HOLD directly, giving out_idx=0 and out_count=0.
- Comparator path: in_data → comparator → max/idx registers, all in one cycle.

## Structure
- Package max_seek_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - the default WIDTH and IDX_W localparams.
- Sub-module greater_than_nbit:
  - combinational unsigned a > b at WIDTH bits;
  - built hierarchically from 2-bit greater and 2-bit equal slices, combining the high slice first;
  - instantiated once, with a=in_data and b=max.
- The controller holds the FSM, the max/idx/cnt/ovf registers and the handshake logic.

## Test plan
- Frame 3,9,2,9,last with out_ready=1 → out_max=9, out_idx=1, out_count=3, out_ovf=0; out_valid for exactly 1 cycle; in_ready low for that cycle.
- Single beat 0xF with in_last, then out_ready held 0 for 5 cycles → out_max=15, idx=0, count=0. Outputs stay stable and in_ready stays 0 throughout; IDLE is re-entered after out_ready rises.
- Frame 1,2,…,15,0,7 (17 beats, IDX_W=4) → out_max=15, out_idx=14, out_count=15, out_ovf=1.
- Random in_valid gaps (about 50%) in the frame 4,4,12,5,last → out_max=12, out_idx=2, out_count=3. Outputs are identical to the gap-free run.
- rst_n pulsed low after 2 beats of 6,8 → outputs reset immediately. The next frame 1,last yields out_max=1, out_idx=0 with no trace of the aborted frame.
- Exhaustive 2-beat frames over all 256 (a,b) pairs → out_idx=1 iff b>a, and out_max = max(a,b) for every pair.

Source files
------------

// File: rtl/max_seek_pkg.sv
// Shared types and default sizing for the streaming maximum-finder.
package max_seek_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/max_seek_ctrl_if.sv
// Input beat stream and result handshake of max_seek_ctrl.
interface max_seek_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_count, out_ovf
  );
endinterface

// File: rtl/greater_than_nbit.sv
// Unsigned a > b built from 2-bit greater/equal slices, resolved from the
// most significant slice downward.
module gt2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq
);
  logic hi_eq;
  assign hi_eq = ~(a[1] ^ b[1]);
  assign gt    = (a[1] & ~b[1]) | (hi_eq & a[0] & ~b[0]);
  assign eq    = hi_eq & ~(a[0] ^ b[0]);
endmodule

module greater_than_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);
  localparam int NS = WIDTH / 2;

  logic [NS-1:0] gt_s;
  logic [NS-1:0] eq_s;

  for (genvar k = 0; k < NS; k++) begin : g_slice
    gt2_slice u_slice (
      .a  (a[2*k+1:2*k]),
      .b  (b[2*k+1:2*k]),
      .gt (gt_s[k]),
      .eq (eq_s[k])
    );
  end

  // A lower slice only decides when every higher slice is equal.
  always_comb begin
    logic g_acc;
    logic e_acc;
    g_acc = 1'b0;
    e_acc = 1'b1;
    for (int k = NS - 1; k >= 0; k--) begin
      g_acc = g_acc | (e_acc & gt_s[k]);
      e_acc = e_acc & eq_s[k];
    end
    gt = g_acc;
  end
endmodule

// File: rtl/max_seek_ctrl.sv
// Frame-level running maximum with a single shared comparator; reports the
// maximum, its first index and the beat count once per frame.
module max_seek_ctrl
  import max_seek_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  max_seek_ctrl_if.slave  bus
);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             data_gt;

  greater_than_nbit #(.WIDTH(WIDTH)) u_gt (
    .a  (bus.in_data),
    .b  (max_q),
    .gt (data_gt)
  );

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_max   = max_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          max_d   = bus.in_data;
          idx_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Once saturated the count freezes, so a late replacement lands on the last index.
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
          if (data_gt) begin
            max_d = bus.in_data;
            idx_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
          end
          if (bus.in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
